// File: rtl/rps_pkg.sv
// Shared codes for the stone-paper-scissors match controller: moves, round results, FSM states.
package rps_pkg;

    localparam int unsigned MOVE_W   = 2;
    localparam int unsigned RESULT_W = 2;
    localparam int unsigned STATE_W  = 3;

    localparam logic [MOVE_W-1:0] MOVE_STONE    = 2'b00;
    localparam logic [MOVE_W-1:0] MOVE_PAPER    = 2'b01;
    localparam logic [MOVE_W-1:0] MOVE_SCISSORS = 2'b10;
    localparam logic [MOVE_W-1:0] MOVE_INVALID  = 2'b11;

    localparam logic [RESULT_W-1:0] RES_TIE     = 2'b00;
    localparam logic [RESULT_W-1:0] RES_P1      = 2'b01;
    localparam logic [RESULT_W-1:0] RES_P2      = 2'b10;
    localparam logic [RESULT_W-1:0] RES_INVALID = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_JUDGE   = 3'd2,
        ST_SCORE   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/rps_round_judge.sv
// Combinational round judge: two captured moves in, result code out.
module rps_round_judge
    import rps_pkg::*;
(
    input  logic [MOVE_W-1:0]   p1_move,
    input  logic [MOVE_W-1:0]   p2_move,
    output logic [RESULT_W-1:0] result_c
);

    logic p1_beats_p2;

    always_comb begin
        p1_beats_p2 = ((p1_move == MOVE_STONE)    && (p2_move == MOVE_SCISSORS)) ||
                      ((p1_move == MOVE_PAPER)    && (p2_move == MOVE_STONE))    ||
                      ((p1_move == MOVE_SCISSORS) && (p2_move == MOVE_PAPER));
        result_c = RES_TIE;
        if ((p1_move == MOVE_INVALID) || (p2_move == MOVE_INVALID)) begin
            result_c = RES_INVALID;
        end else if (p1_move == p2_move) begin
            result_c = RES_TIE;
        end else if (p1_beats_p2) begin
            result_c = RES_P1;
        end else begin
            result_c = RES_P2;
        end
    end

endmodule

// File: rtl/rps_match_controller.sv
// Best-of-N stone-paper-scissors match sequencer: move handshake, per-round timeout,
// judging, scoring and match-winner declaration.
module rps_match_controller
    import rps_pkg::*;
#(
    parameter int unsigned WIN_TARGET     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SCORE_W        = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                match_start,
    input  logic                abort,
    input  logic                p1_valid,
    input  logic [MOVE_W-1:0]   p1_move,
    input  logic                p2_valid,
    input  logic [MOVE_W-1:0]   p2_move,
    output logic                p1_locked,
    output logic                p2_locked,
    output logic                round_done,
    output logic [RESULT_W-1:0] round_result,
    output logic [SCORE_W-1:0]  p1_score,
    output logic [SCORE_W-1:0]  p2_score,
    output logic [7:0]          round_count,
    output logic                match_done,
    output logic [1:0]          match_winner,
    output logic [STATE_W-1:0]  state
);

    localparam int unsigned         TMR_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0]  SCORE_TGT  = SCORE_W'(WIN_TARGET);

    state_e               state_q, state_d;
    logic                 p1_lock_q, p1_lock_d, p2_lock_q, p2_lock_d;
    logic [MOVE_W-1:0]    p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 timeout_q, timeout_d;
    logic [RESULT_W-1:0]  result_q, result_d;
    logic                 round_done_q, round_done_d;
    logic [SCORE_W-1:0]   p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [7:0]           round_cnt_q, round_cnt_d;
    logic                 match_done_q, match_done_d;
    logic [1:0]           winner_q, winner_d;
    logic [RESULT_W-1:0]  judge_res_c;

    rps_round_judge u_judge (
        .p1_move  (p1_mv_q),
        .p2_move  (p2_mv_q),
        .result_c (judge_res_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            p1_lock_q    <= 1'b0;
            p2_lock_q    <= 1'b0;
            p1_mv_q      <= '0;
            p2_mv_q      <= '0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            result_q     <= '0;
            round_done_q <= 1'b0;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            round_cnt_q  <= '0;
            match_done_q <= 1'b0;
            winner_q     <= '0;
        end else begin
            state_q      <= state_d;
            p1_lock_q    <= p1_lock_d;
            p2_lock_q    <= p2_lock_d;
            p1_mv_q      <= p1_mv_d;
            p2_mv_q      <= p2_mv_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            result_q     <= result_d;
            round_done_q <= round_done_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            round_cnt_q  <= round_cnt_d;
            match_done_q <= match_done_d;
            winner_q     <= winner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        p1_lock_d    = p1_lock_q;
        p2_lock_d    = p2_lock_q;
        p1_mv_d      = p1_mv_q;
        p2_mv_d      = p2_mv_q;
        timer_d      = timer_q;
        timeout_d    = timeout_q;
        result_d     = result_q;
        round_done_d = 1'b0;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        round_cnt_d  = round_cnt_q;
        match_done_d = match_done_q;
        winner_d     = winner_q;

        if (abort) begin
            // round_result is left holding the last judged round
            state_d      = ST_IDLE;
            p1_lock_d    = 1'b0;
            p2_lock_d    = 1'b0;
            timer_d      = '0;
            timeout_d    = 1'b0;
            p1_score_d   = '0;
            p2_score_d   = '0;
            round_cnt_d  = '0;
            match_done_d = 1'b0;
            winner_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (match_start) begin
                        state_d      = ST_COLLECT;
                        p1_lock_d    = 1'b0;
                        p2_lock_d    = 1'b0;
                        timer_d      = '0;
                        timeout_d    = 1'b0;
                        result_d     = '0;
                        p1_score_d   = '0;
                        p2_score_d   = '0;
                        round_cnt_d  = '0;
                        match_done_d = 1'b0;
                        winner_d     = '0;
                    end
                end
                ST_COLLECT: begin
                    if (!p1_lock_q && p1_valid) begin
                        p1_lock_d = 1'b1;
                        p1_mv_d   = p1_move;
                    end
                    if (!p2_lock_q && p2_valid) begin
                        p2_lock_d = 1'b1;
                        p2_mv_d   = p2_move;
                    end
                    // a lock landing on the final timer edge still wins over the timeout
                    if (p1_lock_d && p2_lock_d) begin
                        state_d = ST_JUDGE;
                    end else if (timer_q == TMR_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_JUDGE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_JUDGE: begin
                    if (timeout_q) begin
                        if (p1_lock_q ^ p2_lock_q) begin
                            result_d = p1_lock_q ? RES_P1 : RES_P2;
                        end else begin
                            result_d = RES_INVALID;
                        end
                    end else begin
                        result_d = judge_res_c;
                    end
                    state_d = ST_SCORE;
                end
                ST_SCORE: begin
                    round_done_d = 1'b1;
                    round_cnt_d  = round_cnt_q + 8'd1;
                    p1_lock_d    = 1'b0;
                    p2_lock_d    = 1'b0;
                    timer_d      = '0;
                    timeout_d    = 1'b0;
                    state_d      = ST_COLLECT;
                    if (result_q == RES_P1) begin
                        p1_score_d = p1_score_q + SCORE_W'(1);
                        if (p1_score_d == SCORE_TGT) begin
                            state_d      = ST_DONE;
                            match_done_d = 1'b1;
                            winner_d     = RES_P1;
                        end
                    end else if (result_q == RES_P2) begin
                        p2_score_d = p2_score_q + SCORE_W'(1);
                        if (p2_score_d == SCORE_TGT) begin
                            state_d      = ST_DONE;
                            match_done_d = 1'b1;
                            winner_d     = RES_P2;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign p1_locked    = p1_lock_q;
    assign p2_locked    = p2_lock_q;
    assign round_done   = round_done_q;
    assign round_result = result_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_count  = round_cnt_q;
    assign match_done   = match_done_q;
    assign match_winner = winner_q;
    assign state        = state_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed bench for rps_match_controller: table of full rounds plus hand sequences
// for lock-once, timeouts, abort and asynchronous reset.
module tb_rps_match_controller;

    logic       clk;
    logic       reset_n;
    logic       match_start;
    logic       abort;
    logic       p1_valid;
    logic [1:0] p1_move;
    logic       p2_valid;
    logic [1:0] p2_move;
    logic       p1_locked;
    logic       p2_locked;
    logic       round_done;
    logic [1:0] round_result;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [7:0] round_count;
    logic       match_done;
    logic [1:0] match_winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    rps_match_controller #(
        .WIN_TARGET     (3),
        .TIMEOUT_CYCLES (8),
        .SCORE_W        (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .match_start  (match_start),
        .abort        (abort),
        .p1_valid     (p1_valid),
        .p1_move      (p1_move),
        .p2_valid     (p2_valid),
        .p2_move      (p2_move),
        .p1_locked    (p1_locked),
        .p2_locked    (p2_locked),
        .round_done   (round_done),
        .round_result (round_result),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .round_count  (round_count),
        .match_done   (match_done),
        .match_winner (match_winner),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [1:0] m1;
        logic [1:0] m2;
        logic [1:0] res;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [7:0] cnt;
        logic [2:0] st;
        logic [1:0] win;
    } vec_t;

    vec_t vecs [11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " state"},        32'(state),        32'd0);
        check({tag, " p1_locked"},    32'(p1_locked),    32'd0);
        check({tag, " p2_locked"},    32'(p2_locked),    32'd0);
        check({tag, " round_done"},   32'(round_done),   32'd0);
        check({tag, " round_result"}, 32'(round_result), 32'd0);
        check({tag, " p1_score"},     32'(p1_score),     32'd0);
        check({tag, " p2_score"},     32'(p2_score),     32'd0);
        check({tag, " round_count"},  32'(round_count),  32'd0);
        check({tag, " match_done"},   32'(match_done),   32'd0);
        check({tag, " match_winner"}, 32'(match_winner), 32'd0);
    endtask

    initial begin
        // start, p1, p2, result, p1_score, p2_score, round_count, state after round, winner
        vecs[0]  = '{1'b1, 2'b00, 2'b10, 2'b01, 4'd1, 4'd0, 8'd1, 3'd1, 2'b00};
        vecs[1]  = '{1'b0, 2'b00, 2'b10, 2'b01, 4'd2, 4'd0, 8'd2, 3'd1, 2'b00};
        vecs[2]  = '{1'b0, 2'b00, 2'b10, 2'b01, 4'd3, 4'd0, 8'd3, 3'd4, 2'b01};
        vecs[3]  = '{1'b1, 2'b01, 2'b01, 2'b00, 4'd0, 4'd0, 8'd1, 3'd1, 2'b00};
        vecs[4]  = '{1'b0, 2'b11, 2'b00, 2'b11, 4'd0, 4'd0, 8'd2, 3'd1, 2'b00};
        vecs[5]  = '{1'b0, 2'b00, 2'b11, 2'b11, 4'd0, 4'd0, 8'd3, 3'd1, 2'b00};
        vecs[6]  = '{1'b0, 2'b10, 2'b00, 2'b10, 4'd0, 4'd1, 8'd4, 3'd1, 2'b00};
        vecs[7]  = '{1'b0, 2'b01, 2'b00, 2'b01, 4'd1, 4'd1, 8'd5, 3'd1, 2'b00};
        vecs[8]  = '{1'b0, 2'b10, 2'b01, 2'b01, 4'd2, 4'd1, 8'd6, 3'd1, 2'b00};
        vecs[9]  = '{1'b0, 2'b00, 2'b01, 2'b10, 4'd2, 4'd2, 8'd7, 3'd1, 2'b00};
        vecs[10] = '{1'b0, 2'b01, 2'b10, 2'b10, 4'd2, 4'd3, 8'd8, 3'd4, 2'b10};

        reset_n     = 1'b0;
        match_start = 1'b0;
        abort       = 1'b0;
        p1_valid    = 1'b0;
        p1_move     = 2'b00;
        p2_valid    = 1'b0;
        p2_move     = 2'b00;
        tick;
        tick;
        check_zero("reset");
        reset_n = 1'b1;
        tick;
        check("idle without start", 32'(state), 32'd0);

        // full rounds from the table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].start) begin
                match_start = 1'b1;
                tick;
                match_start = 1'b0;
                check($sformatf("v%0d start state", i), 32'(state), 32'd1);
                check($sformatf("v%0d start p1_score", i), 32'(p1_score), 32'd0);
                check($sformatf("v%0d start round_count", i), 32'(round_count), 32'd0);
                check($sformatf("v%0d start match_done", i), 32'(match_done), 32'd0);
            end
            p1_valid = 1'b1;
            p2_valid = 1'b1;
            p1_move  = vecs[i].m1;
            p2_move  = vecs[i].m2;
            tick;
            p1_valid = 1'b0;
            p2_valid = 1'b0;
            check($sformatf("v%0d judge state", i), 32'(state), 32'd2);
            check($sformatf("v%0d locks", i), 32'({p1_locked, p2_locked}), 32'd3);
            check($sformatf("v%0d round_done low", i), 32'(round_done), 32'd0);
            tick;
            check($sformatf("v%0d score state", i), 32'(state), 32'd3);
            check($sformatf("v%0d result", i), 32'(round_result), 32'(vecs[i].res));
            tick;
            check($sformatf("v%0d round_done", i), 32'(round_done), 32'd1);
            check($sformatf("v%0d p1_score", i), 32'(p1_score), 32'(vecs[i].s1));
            check($sformatf("v%0d p2_score", i), 32'(p2_score), 32'(vecs[i].s2));
            check($sformatf("v%0d round_count", i), 32'(round_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d next state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d match_done", i), 32'(match_done), 32'(vecs[i].st == 3'd4));
            check($sformatf("v%0d match_winner", i), 32'(match_winner), 32'(vecs[i].win));
            check($sformatf("v%0d locks cleared", i), 32'({p1_locked, p2_locked}), 32'd0);
        end
        tick;
        check("round_done pulse ends", 32'(round_done), 32'd0);
        check("done holds result", 32'(round_result), 32'd2);

        // lock-once: later P1 valids are ignored
        match_start = 1'b1;
        tick;
        match_start = 1'b0;
        p1_valid = 1'b1;
        p1_move  = 2'b00;
        tick;
        check("lock1 p1_locked", 32'(p1_locked), 32'd1);
        check("lock1 p2_locked", 32'(p2_locked), 32'd0);
        p1_move = 2'b01;
        tick;
        check("lock1 still collect", 32'(state), 32'd1);
        p1_valid = 1'b0;
        p2_valid = 1'b1;
        p2_move  = 2'b01;
        tick;
        p2_valid = 1'b0;
        check("lock1 judge", 32'(state), 32'd2);
        tick;
        check("lock1 result", 32'(round_result), 32'd2);
        tick;
        check("lock1 p2_score", 32'(p2_score), 32'd1);
        check("lock1 p1_score", 32'(p1_score), 32'd0);

        // timeout with only P2 locked
        p2_valid = 1'b1;
        p2_move  = 2'b10;
        repeat (7) tick;
        p2_valid = 1'b0;
        check("to_p2 still collect", 32'(state), 32'd1);
        check("to_p2 locks", 32'({p1_locked, p2_locked}), 32'd1);
        tick;
        check("to_p2 judge", 32'(state), 32'd2);
        tick;
        check("to_p2 result", 32'(round_result), 32'd2);
        tick;
        check("to_p2 p2_score", 32'(p2_score), 32'd2);
        check("to_p2 round_count", 32'(round_count), 32'd2);
        check("to_p2 round_done", 32'(round_done), 32'd1);

        // timeout with neither locked
        repeat (7) tick;
        check("to_none still collect", 32'(state), 32'd1);
        tick;
        check("to_none judge", 32'(state), 32'd2);
        tick;
        check("to_none result", 32'(round_result), 32'd3);
        tick;
        check("to_none p1_score", 32'(p1_score), 32'd0);
        check("to_none p2_score", 32'(p2_score), 32'd2);
        check("to_none round_count", 32'(round_count), 32'd3);

        // both lock on the final timer edge: normal round
        repeat (7) tick;
        check("edge8 still collect", 32'(state), 32'd1);
        p1_valid = 1'b1;
        p2_valid = 1'b1;
        p1_move  = 2'b01;
        p2_move  = 2'b00;
        tick;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        check("edge8 judge", 32'(state), 32'd2);
        tick;
        check("edge8 result", 32'(round_result), 32'd1);
        tick;
        check("edge8 p1_score", 32'(p1_score), 32'd1);
        check("edge8 round_count", 32'(round_count), 32'd4);
        check("edge8 state", 32'(state), 32'd1);

        // abort beats a simultaneous match_start
        p1_valid = 1'b1;
        p1_move  = 2'b00;
        tick;
        p1_valid = 1'b0;
        check("abort pre lock", 32'(p1_locked), 32'd1);
        abort       = 1'b1;
        match_start = 1'b1;
        tick;
        abort       = 1'b0;
        match_start = 1'b0;
        check("abort state", 32'(state), 32'd0);
        check("abort p1_score", 32'(p1_score), 32'd0);
        check("abort p2_score", 32'(p2_score), 32'd0);
        check("abort round_count", 32'(round_count), 32'd0);
        check("abort locks", 32'({p1_locked, p2_locked}), 32'd0);
        tick;
        tick;
        check("abort stays idle", 32'(state), 32'd0);

        // asynchronous reset in JUDGE
        match_start = 1'b1;
        tick;
        match_start = 1'b0;
        p1_valid = 1'b1;
        p2_valid = 1'b1;
        p1_move  = 2'b00;
        p2_move  = 2'b10;
        tick;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        tick;
        tick;
        check("rst pre p1_score", 32'(p1_score), 32'd1);
        p1_valid = 1'b1;
        p2_valid = 1'b1;
        p1_move  = 2'b01;
        p2_move  = 2'b01;
        tick;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        check("rst pre judge", 32'(state), 32'd2);
        reset_n = 1'b0;
        #1;
        check_zero("midjudge reset");
        #1;
        reset_n = 1'b1;
        tick;
        tick;
        check("post reset idle", 32'(state), 32'd0);
        match_start = 1'b1;
        tick;
        match_start = 1'b0;
        check("post reset start", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
